// File: rtl/alu_commit_pkg.sv
// Shared types and constants for the ALU writeback commit block.
// Register indices follow the Z80 encoding; flag positions follow the Z80 F register layout.
package alu_commit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    localparam logic [2:0] REG_B = 3'd0;
    localparam logic [2:0] REG_C = 3'd1;
    localparam logic [2:0] REG_D = 3'd2;
    localparam logic [2:0] REG_E = 3'd3;
    localparam logic [2:0] REG_H = 3'd4;
    localparam logic [2:0] REG_L = 3'd5;
    localparam logic [2:0] REG_A = 3'd7;

    localparam int FLG_C  = 0;
    localparam int FLG_N  = 1;
    localparam int FLG_PV = 2;
    localparam int FLG_H  = 4;
    localparam int FLG_Z  = 6;
    localparam int FLG_S  = 7;

endpackage

// File: rtl/alu_commit.sv
// Writeback commit: ALU result to the 8-bit RF write port (wide results as two byte writes)
// and masked flag update of F. Optional commit counter under `ALU_COMMIT_STATS_EN.
module alu_commit
    import alu_commit_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int FLAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   in_result,
    input  logic [FLAG_W-1:0]     in_flags,
    input  logic [FLAG_W-1:0]     in_flag_mask,
    input  logic [REG_AW-1:0]     in_dest,
    input  logic                  in_wide,
    input  logic                  in_rf_wr,
    output logic                  rf_we,
    output logic [REG_AW-1:0]     rf_addr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [FLAG_W-1:0]     flags_q,
    output logic                  commit_done
`ifdef ALU_COMMIT_STATS_EN
    ,
    output logic [15:0]           commit_count
`endif
);

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   hold_hi;
    logic [REG_AW-2:0]   hold_pair;
    logic                hold_wide;
    logic                accept;

    logic                rf_we_nxt;
    logic [REG_AW-1:0]   rf_addr_nxt;
    logic [DATA_W-1:0]   rf_wdata_nxt;
    logic [FLAG_W-1:0]   flags_nxt;
    logic                done_nxt;

    // A flags-only commit keeps the FSM in IDLE; holding ready low during its
    // commit cycle keeps every transaction at one accept per two cycles or slower.
    assign in_ready = (state == IDLE) && !commit_done;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_hi     <= '0;
            hold_pair   <= '0;
            hold_wide   <= 1'b0;
            rf_we       <= 1'b0;
            rf_addr     <= '0;
            rf_wdata    <= '0;
            flags_q     <= '0;
            commit_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            rf_we       <= rf_we_nxt;
            rf_addr     <= rf_addr_nxt;
            rf_wdata    <= rf_wdata_nxt;
            flags_q     <= flags_nxt;
            commit_done <= done_nxt;
            if (accept) begin
                hold_hi   <= in_result[2*DATA_W-1:DATA_W];
                hold_pair <= in_dest[REG_AW-1:1];
                hold_wide <= in_wide;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && in_rf_wr) state_nxt = WR_LO;
            WR_LO:   state_nxt = hold_wide ? WR_HI : IDLE;
            WR_HI:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered: these are the values shown in the cycle after the edge.
    always_comb begin
        rf_we_nxt    = 1'b0;
        rf_addr_nxt  = rf_addr;
        rf_wdata_nxt = rf_wdata;
        flags_nxt    = flags_q;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    flags_nxt = (flags_q & ~in_flag_mask) | (in_flags & in_flag_mask);
                    if (in_rf_wr) begin
                        rf_we_nxt    = 1'b1;
                        rf_addr_nxt  = in_wide ? {in_dest[REG_AW-1:1], 1'b1} : in_dest;
                        rf_wdata_nxt = in_result[DATA_W-1:0];
                        done_nxt     = !in_wide;
                    end else begin
                        done_nxt     = 1'b1;
                    end
                end
            end
            WR_LO: begin
                if (hold_wide) begin
                    rf_we_nxt    = 1'b1;
                    rf_addr_nxt  = {hold_pair, 1'b0};
                    rf_wdata_nxt = hold_hi;
                    done_nxt     = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef ALU_COMMIT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            commit_count <= '0;
        else if (commit_done && commit_count != 16'hFFFF)
            commit_count <= commit_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_alu_commit.sv
// Directed bench for alu_commit: transaction-level model expands each accepted op into
// its expected per-cycle outputs; one negedge process compares every cycle.
module tb_alu_commit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic [7:0]  in_flags = '0;
    logic [7:0]  in_flag_mask = '0;
    logic [2:0]  in_dest = '0;
    logic        in_wide = 1'b0;
    logic        in_rf_wr = 1'b0;
    logic        rf_we;
    logic [2:0]  rf_addr;
    logic [7:0]  rf_wdata;
    logic [7:0]  flags_q;
    logic        commit_done;
`ifdef ALU_COMMIT_STATS_EN
    logic [15:0] commit_count;
`endif

    alu_commit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_flag_mask(in_flag_mask),
        .in_dest(in_dest), .in_wide(in_wide), .in_rf_wr(in_rf_wr),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .flags_q(flags_q), .commit_done(commit_done)
`ifdef ALU_COMMIT_STATS_EN
        , .commit_count(commit_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: each accepted op becomes a list of busy cycles
    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] flags;
        logic       done;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  m_flags = '0;
    logic [2:0]  m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic        m_ready = 1'b1;
    logic [15:0] m_commits = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            m_flags = '0; m_addr = '0; m_wdata = '0; m_ready = 1'b1; m_commits = '0;
            chk("rst_we", rf_we, 0);
            chk("rst_addr", rf_addr, 0);
            chk("rst_wdata", rf_wdata, 0);
            chk("rst_flags", flags_q, 0);
            chk("rst_done", commit_done, 0);
            chk("rst_ready", in_ready, 1);
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                m_ready = 1'b0;
            end else begin
                e = '{we: 1'b0, addr: m_addr, wdata: m_wdata, flags: m_flags, done: 1'b0};
                m_ready = 1'b1;
            end
            chk("ready", in_ready, m_ready);
            chk("we", rf_we, e.we);
            chk("addr", rf_addr, e.addr);
            chk("wdata", rf_wdata, e.wdata);
            chk("flags", flags_q, e.flags);
            chk("done", commit_done, e.done);
`ifdef ALU_COMMIT_STATS_EN
            chk("count", commit_count, m_commits);
`endif
            if (e.done && m_commits != 16'hFFFF) m_commits = m_commits + 16'd1;
            if (in_valid && m_ready) begin
                m_flags = (m_flags & ~in_flag_mask) | (in_flags & in_flag_mask);
                if (!in_rf_wr) begin
                    q.push_back('{1'b0, m_addr, m_wdata, m_flags, 1'b1});
                end else if (!in_wide) begin
                    m_addr = in_dest; m_wdata = in_result[7:0];
                    q.push_back('{1'b1, m_addr, m_wdata, m_flags, 1'b1});
                end else begin
                    m_addr = in_dest | 3'd1; m_wdata = in_result[7:0];
                    q.push_back('{1'b1, m_addr, m_wdata, m_flags, 1'b0});
                    m_addr = in_dest & 3'b110; m_wdata = in_result[15:8];
                    q.push_back('{1'b1, m_addr, m_wdata, m_flags, 1'b1});
                end
            end
        end
    end

    // Register-file image as written through the DUT's port
    logic [7:0] rf_img [8];
    initial for (int i = 0; i < 8; i++) rf_img[i] = 8'h00;
    always @(posedge clk) if (rst_n && rf_we) rf_img[rf_addr] <= rf_wdata;

    // ---------------- stimulus (called at posedge+1, returns at posedge+1 after accept)
    task automatic send(input logic [15:0] r, input logic [7:0] f, input logic [7:0] m,
                        input logic [2:0] d, input logic w, input logic wr, output int waited);
        in_result = r; in_flags = f; in_flag_mask = m; in_dest = d; in_wide = w; in_rf_wr = wr;
        in_valid = 1'b1;
        waited = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            waited++;
            if (m_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int w;

    initial begin
        #2 rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("init_flags", flags_q, 8'h00);
        chk("init_ready", in_ready, 1);

        // narrow write to A
        send(16'h00A5, 8'h81, 8'hFF, 3'd7, 1'b0, 1'b1, w);
        chk("nar_we", rf_we, 1);
        chk("nar_addr", rf_addr, 7);
        chk("nar_wdata", rf_wdata, 8'hA5);
        chk("nar_flags", flags_q, 8'h81);
        chk("nar_done", commit_done, 1);
        idle(1);

        // wide write to DE, flags untouched
        send(16'h1234, 8'h00, 8'h00, 3'd2, 1'b1, 1'b1, w);
        chk("wide_lo_addr", rf_addr, 3);
        chk("wide_lo_wdata", rf_wdata, 8'h34);
        chk("wide_lo_done", commit_done, 0);
        chk("wide_lo_ready", in_ready, 0);
        idle(1);
        chk("wide_hi_addr", rf_addr, 2);
        chk("wide_hi_wdata", rf_wdata, 8'h12);
        chk("wide_hi_done", commit_done, 1);
        chk("wide_hi_ready", in_ready, 0);
        chk("wide_flags", flags_q, 8'h81);
        idle(1);

        // flags-only ops with masks
        send(16'h0000, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b0, w);
        send(16'h0000, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0, w);
        chk("fo_flags", flags_q, 8'hFE);
        chk("fo_we", rf_we, 0);
        chk("fo_done", commit_done, 1);
        idle(1);

        // back-to-back: narrow held behind a wide op
        send(16'h5678, 8'h00, 8'h00, 3'd4, 1'b1, 1'b1, w);
        send(16'h00C3, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, w);
        chk("bp_wait", w, 3);
        idle(2);
        chk("bp_rf_h", rf_img[4], 8'h56);
        chk("bp_rf_l", rf_img[5], 8'h78);
        chk("bp_rf_b", rf_img[0], 8'hC3);

        // odd destination on a wide op
        send(16'h9ABC, 8'h00, 8'h00, 3'd5, 1'b1, 1'b1, w);
        idle(3);
        chk("odd_rf_h", rf_img[4], 8'h9A);
        chk("odd_rf_l", rf_img[5], 8'hBC);
        chk("odd_rf_d", rf_img[2], 8'h12);

        // reset during WR_HI drops the high byte
        send(16'hDEAD, 8'h55, 8'hFF, 3'd2, 1'b1, 1'b1, w);
        idle(1);
        rst_n = 1'b0;
        idle(2);
        chk("abort_rf_d", rf_img[2], 8'h12);
        chk("abort_rf_e", rf_img[3], 8'hAD);
        chk("abort_flags", flags_q, 8'h00);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("abort_ready", in_ready, 1);
        idle(1);

`ifdef ALU_COMMIT_STATS_EN
        for (int i = 0; i < 5; i++) send(16'h0011, 8'h00, 8'h00, 3'd1, 1'b0, 1'b1, w);
        idle(2);
        chk("stat_five", commit_count, 16'd5);
        force dut.commit_count = 16'hFFFF;
        m_commits = 16'hFFFF;
        idle(1);
        release dut.commit_count;
        send(16'h0022, 8'h00, 8'h00, 3'd1, 1'b0, 1'b1, w);
        idle(2);
        chk("stat_sat", commit_count, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
